// File: rtl/fft_frame_source.sv
// fft_frame_source: AXI-Stream master feeding an FFT core's config and data
// slave channels from a free-running sample stream. Samples are buffered in a
// small FIFO, the config word is sent before the first frame and after every
// cfg_update, and frames of 2**LOG2_FRAME beats are delimited with tlast.
// Optional feature macro: FFT_SRC_ERR_CNT_EN (adds err_clear / err_count).
module fft_frame_source #(
  parameter int               DATA_W     = 32,
  parameter int               CFG_W      = 16,
  parameter int               LOG2_FRAME = 10,
  parameter int               FIFO_DEPTH = 16,
  parameter logic [CFG_W-1:0] CFG_RESET  = 16'h0001
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [CFG_W-1:0]  cfg_word,
  input  logic              cfg_update,
  input  logic [DATA_W-1:0] s_sample_tdata,
  input  logic              s_sample_tvalid,
  output logic              s_sample_tready,
  output logic [CFG_W-1:0]  m_axis_config_tdata,
  output logic              m_axis_config_tvalid,
  input  logic              m_axis_config_tready,
  output logic [DATA_W-1:0] m_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic              m_axis_data_tlast,
  input  logic              event_tlast_unexpected,
  input  logic              event_tlast_missing,
  output logic [15:0]       frame_count,
  output logic              busy,
  output logic              overflow
`ifdef FFT_SRC_ERR_CNT_EN
  ,
  input  logic              err_clear,
  output logic [7:0]        err_count
`endif
);

  localparam int                  AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]         FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [LOG2_FRAME-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {IDLE, CONFIG, STREAM} state_t;

  state_t                  state;
  logic [DATA_W-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic                    ready_en;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [CFG_W-1:0]        cfg_reg;
  logic                    cfg_pending;
  logic                    cfg_due;
  logic [CFG_W-1:0]        cfg_next;
  logic [LOG2_FRAME-1:0]   beat;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign s_sample_tready      = ready_en & ~full;
  assign push                 = s_sample_tvalid & s_sample_tready;
  assign m_axis_data_tvalid   = (state == STREAM) & ~empty;
  assign m_axis_data_tdata    = mem[rd_ptr];
  assign m_axis_data_tlast    = m_axis_data_tvalid & (beat == LAST_BEAT);
  assign pop                  = m_axis_data_tvalid & m_axis_data_tready;
  assign m_axis_config_tvalid = (state == CONFIG);
  assign busy                 = (state != IDLE);

  // An update arriving on a frame boundary is honoured immediately.
  assign cfg_due  = cfg_pending | cfg_update;
  assign cfg_next = cfg_update ? cfg_word : cfg_reg;

  // Sample FIFO storage, pointers and occupancy.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_sample_tdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Upstream ready release one cycle after reset, and sticky overflow flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (s_sample_tvalid & ready_en & full) overflow <= 1'b1;
    end
  end

  // Frame FSM: config handshake, beat counting, frame boundaries.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state               <= IDLE;
      cfg_reg             <= CFG_RESET;
      cfg_pending         <= 1'b1;
      m_axis_config_tdata <= '0;
      beat                <= '0;
      frame_count         <= '0;
    end else begin
      if (cfg_update) begin
        cfg_reg     <= cfg_word;
        cfg_pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            if (cfg_due) begin
              state               <= CONFIG;
              m_axis_config_tdata <= cfg_next;
            end else begin
              state <= STREAM;
            end
          end
        end
        CONFIG: begin
          // tdata was captured on entry, so a late update waits for the next boundary.
          if (m_axis_config_tready) begin
            state <= STREAM;
            if (!cfg_update) cfg_pending <= 1'b0;
          end
        end
        STREAM: begin
          if (pop) begin
            if (beat == LAST_BEAT) begin
              beat        <= '0;
              frame_count <= frame_count + 16'd1;
              if (enable & cfg_due) begin
                state               <= CONFIG;
                m_axis_config_tdata <= cfg_next;
              end else if (!enable) begin
                state <= IDLE;
              end
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FFT_SRC_ERR_CNT_EN
  // Saturating count of cycles with any FFT framing error event.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= '0;
    end else if ((event_tlast_unexpected | event_tlast_missing) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  logic unused_events;
  assign unused_events = event_tlast_unexpected | event_tlast_missing;
`endif

endmodule

// File: tb/tb_fft_frame_source.sv
// Self-checking bench for fft_frame_source (LOG2_FRAME=3, FIFO_DEPTH=16).
// Reference model: sample queue, beat/frame tally and config-due flag.
module tb_fft_frame_source;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] cfg_word = '0;
  logic        cfg_update = 1'b0;
  logic [31:0] s_sample_tdata = '0;
  logic        s_sample_tvalid = 1'b0;
  logic        s_sample_tready;
  logic [15:0] m_axis_config_tdata;
  logic        m_axis_config_tvalid;
  logic        m_axis_config_tready = 1'b0;
  logic [31:0] m_axis_data_tdata;
  logic        m_axis_data_tvalid;
  logic        m_axis_data_tready = 1'b0;
  logic        m_axis_data_tlast;
  logic        event_tlast_unexpected = 1'b0;
  logic        event_tlast_missing = 1'b0;
  logic [15:0] frame_count;
  logic        busy;
  logic        overflow;
`ifdef FFT_SRC_ERR_CNT_EN
  logic        err_clear = 1'b0;
  logic [7:0]  err_count;
`endif

  fft_frame_source #(
    .DATA_W(32), .CFG_W(16), .LOG2_FRAME(3), .FIFO_DEPTH(16), .CFG_RESET(16'h0001)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .cfg_word(cfg_word), .cfg_update(cfg_update),
    .s_sample_tdata(s_sample_tdata), .s_sample_tvalid(s_sample_tvalid),
    .s_sample_tready(s_sample_tready),
    .m_axis_config_tdata(m_axis_config_tdata), .m_axis_config_tvalid(m_axis_config_tvalid),
    .m_axis_config_tready(m_axis_config_tready),
    .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tvalid(m_axis_data_tvalid),
    .m_axis_data_tready(m_axis_data_tready), .m_axis_data_tlast(m_axis_data_tlast),
    .event_tlast_unexpected(event_tlast_unexpected), .event_tlast_missing(event_tlast_missing),
    .frame_count(frame_count), .busy(busy), .overflow(overflow)
`ifdef FFT_SRC_ERR_CNT_EN
    , .err_clear(err_clear), .err_count(err_count)
`endif
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] q[$];
  int          beat_m;
  int          frames_m;
  bit          need_cfg;
  logic [15:0] latest;
  bit          ov_m;
  bit          cfg_stall;
  logic [15:0] cfg_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    beat_m    = 0;
    frames_m  = 0;
    need_cfg  = 1'b1;
    latest    = 16'h0001;
    ov_m      = 1'b0;
    cfg_stall = 1'b0;
    cfg_prev  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tready"}, s_sample_tready, 0);
    chk({tag, "_cfg_valid"}, m_axis_config_tvalid, 0);
    chk({tag, "_cfg_data"}, m_axis_config_tdata, 0);
    chk({tag, "_dat_valid"}, m_axis_data_tvalid, 0);
    chk({tag, "_dat_data"}, m_axis_data_tdata, 0);
    chk({tag, "_tlast"}, m_axis_data_tlast, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overflow"}, overflow, 0);
`ifdef FFT_SRC_ERR_CNT_EN
    chk({tag, "_err_count"}, err_count, 0);
`endif
  endtask

  // Called at a negedge: check outputs against the model, drive the next
  // inputs, advance the model by the handshakes of the coming posedge.
  task automatic step(input bit en, input bit crdy, input bit drdy, input bit sv,
                      input logic [31:0] sd, input bit cu, input logic [15:0] cw);
    bit chs, dhs, psh;
    chk("s_tready", s_sample_tready, q.size() < 16);
    chk("overflow", overflow, ov_m);
    chk("frame_count", frame_count, frames_m[15:0]);
    if (q.size() == 0) chk("valid_without_data", m_axis_data_tvalid, 0);
    if (need_cfg && beat_m == 0) chk("data_before_cfg", m_axis_data_tvalid, 0);
    if (m_axis_data_tvalid && q.size() > 0) begin
      chk("data", m_axis_data_tdata, q[0]);
      chk("tlast", m_axis_data_tlast, beat_m == 7);
    end
    if (!(need_cfg && beat_m == 0)) chk("cfg_unexpected", m_axis_config_tvalid, 0);
    if (m_axis_config_tvalid) chk("cfg_word", m_axis_config_tdata, latest);
    if (cfg_stall) begin
      chk("cfg_hold_valid", m_axis_config_tvalid, 1);
      chk("cfg_hold_data", m_axis_config_tdata, cfg_prev);
    end

    enable               = en;
    m_axis_config_tready = crdy;
    m_axis_data_tready   = drdy;
    s_sample_tvalid      = sv;
    s_sample_tdata       = sd;
    cfg_update           = cu;
    cfg_word             = cw;

    chs = m_axis_config_tvalid & crdy;
    dhs = m_axis_data_tvalid & drdy;
    psh = sv & s_sample_tready;
    cfg_stall = m_axis_config_tvalid & !crdy;
    cfg_prev  = m_axis_config_tdata;
    if (sv && q.size() == 16) ov_m = 1'b1;
    if (dhs && q.size() > 0) begin
      void'(q.pop_front());
      beat_m++;
      if (beat_m == 8) begin
        beat_m = 0;
        frames_m++;
      end
    end
    if (psh) q.push_back(sd);
    if (cu) begin
      latest   = cw;
      need_cfg = 1'b1;
    end else if (chs) begin
      need_cfg = 1'b0;
    end
    @(posedge aclk);
    @(negedge aclk);
  endtask

  initial begin
    int pushed;
    bit cu_done;
    bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    model_reset();
    #1;
    check_reset_outputs("reset");
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);

    // Frame 1: samples 1..8, config tready held low for 5 cycles.
    for (int i = 0; i < 8; i++) begin
      step(1, i >= 6, 1, 1, 32'(i + 1), 0, 16'h0);
      if (i == 0) begin
        chk("cfg_first_cycle", m_axis_config_tvalid, 1);
        chk("cfg_first_word", m_axis_config_tdata, 16'h0001);
        chk("busy_config", busy, 1);
      end
    end
    // Data tready pattern 1,0,0,1 while the frame drains.
    for (int i = 0; i < 40 && frames_m < 1; i++)
      step(1, 1, rdy_pat[i % 4], 0, 32'h0, 0, 16'h0);
    chk("frame1_done", frames_m, 1);
    chk("frame1_count", frame_count, 16'd1);

    // Frames 2 and 3: cfg_update to 0x0000 at beat 3 of frame 2.
    pushed  = 0;
    cu_done = 1'b0;
    for (int i = 0; i < 100 && frames_m < 3; i++) begin
      bit cu;
      cu = (!cu_done && beat_m == 3 && frames_m == 1);
      if (cu) cu_done = 1'b1;
      step(1, 1, 1, pushed < 16, 32'(9 + pushed), cu, 16'h0000);
      if (pushed < 16) pushed++;
    end
    chk("cfg_update_applied", cu_done, 1);
    chk("frame3_done", frames_m, 3);
    chk("cfg_cleared", need_cfg, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bit cu;
      cu = (beat_m >= 1 && beat_m <= 6 && $urandom_range(0, 15) == 0);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6, $urandom, cu, 16'($urandom));
    end

    // Drain to a frame boundary with nothing queued and no config due.
    for (int i = 0; i < 300 && !(q.size() == 0 && beat_m == 0 && !need_cfg); i++)
      step(1, 1, 1, ((beat_m + q.size()) % 8) != 0, $urandom, 0, 16'h0);
    chk("drain", q.size() == 0 && beat_m == 0 && !need_cfg, 1);

    // Overflow: 17 samples offered with the data channel stalled.
    for (int i = 0; i < 17; i++) step(1, 1, 0, 1, $urandom, 0, 16'h0);
    chk("full_tready", s_sample_tready, 0);
    chk("overflow_set", overflow, 1);
    chk("overflow_model", ov_m, 1);

    // Let a few beats out, then reset mid-frame.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 32'h0, 0, 16'h0);
    enable = 0; m_axis_config_tready = 0; m_axis_data_tready = 0;
    s_sample_tvalid = 0; cfg_update = 0;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    pushed = 0;
    for (int i = 0; i < 60 && frames_m < 1; i++) begin
      step(1, 1, 1, pushed < 8, 32'(100 + pushed), 0, 16'h0);
      if (pushed < 8) pushed++;
    end
    chk("post_reset_frame", frames_m, 1);
    chk("post_reset_cfg", need_cfg, 0);

`ifdef FFT_SRC_ERR_CNT_EN
    for (int i = 0; i < 3; i++) begin
      event_tlast_unexpected = 1'b1;
      event_tlast_missing    = 1'b1;
      step(0, 1, 1, 0, 32'h0, 0, 16'h0);
      event_tlast_unexpected = 1'b0;
      event_tlast_missing    = 1'b0;
      step(0, 1, 1, 0, 32'h0, 0, 16'h0);
    end
    chk("err_count_3", err_count, 8'd3);
    event_tlast_missing = 1'b1;
    err_clear           = 1'b1;
    step(0, 1, 1, 0, 32'h0, 0, 16'h0);
    event_tlast_missing = 1'b0;
    err_clear           = 1'b0;
    chk("err_clear_wins", err_count, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_frame_source.md
Name: fft_frame_source

Overview:
- AXI-Stream master that feeds an FFT core's config and data slave channels from a free-running upstream sample stream.
- Buffers incoming samples in a small FIFO and issues the configuration word before the first frame and whenever a new one is requested.
- Cuts the stream into frames of FRAME_LEN samples with tlast on the final beat.
- Counts completed frames and reports FFT framing error events back to the control logic.

Parameters:
- DATA_W, 32, sample width (packed {im[15:0], re[15:0]}).
- CFG_W, 16, config word width.
- LOG2_FRAME, 10, log2 of frame length (FRAME_LEN = 2**LOG2_FRAME).
- FIFO_DEPTH, 16, sample FIFO entries (power of two, ≥2).
- CFG_RESET, 16'h0001, config word in use after reset (forward transform).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  allow frames to start
- cfg_word  in  CFG_W  new config word
- cfg_update  in  1  one-cycle pulse: latch cfg_word, resend before next frame
- s_sample_tdata  in  DATA_W  upstream sample
- s_sample_tvalid  in  1  upstream valid
- s_sample_tready  out  1  FIFO not full
- m_axis_config_tdata  out  CFG_W  to FFT config slave
- m_axis_config_tvalid  out  1
- m_axis_config_tready  in  1
- m_axis_data_tdata  out  DATA_W  to FFT data slave
- m_axis_data_tvalid  out  1
- m_axis_data_tready  in  1
- m_axis_data_tlast  out  1  last beat of frame
- event_tlast_unexpected  in  1  from FFT
- event_tlast_missing  in  1  from FFT
- frame_count  out  16  completed frames, wraps at 16'hFFFF→0
- busy  out  1  state ≠ IDLE
- overflow  out  1  sticky: a sample was offered while the FIFO was full

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, state IDLE, cfg register = CFG_RESET, cfg_pending = 1, beat counter = 0.
  - s_sample_tready rises the first cycle after release.
- FIFO:
  - Push on s_sample_tvalid & s_sample_tready; pop on m_axis_data_tvalid & m_axis_data_tready.
  - Simultaneous push and pop when full is not allowed (tready is 0 when full). Simultaneous push and pop at any other level leaves the count unchanged.
  - s_sample_tvalid & !s_sample_tready sets overflow (sticky until reset). The sample is dropped at the source, never inside the block.
- FSM states and transitions:
  - IDLE: if enable & cfg_pending → CONFIG; else if enable → STREAM.
  - CONFIG: m_axis_config_tvalid = 1, tdata = cfg register. Hold both stable until tready. On the handshake, clear cfg_pending and go to STREAM. If cfg_update arrives in CONFIG, the new word is used on the next boundary, not mid-handshake.
  - STREAM: m_axis_data_tvalid = FIFO non-empty, tdata = FIFO head (combinational from storage, stable while stalled). Each handshake increments the beat counter.
    - m_axis_data_tlast = (beat counter == FRAME_LEN-1) & tvalid.
    - On the tlast handshake: counter → 0, frame_count += 1, then → CONFIG if cfg_pending & enable, → STREAM if enable, else → IDLE.
- Latency:
  - Sample to m_axis_data_tvalid: 1 cycle after push when the FIFO was empty in STREAM.
  - Config tvalid: first cycle in CONFIG.
- Once asserted, tvalid is never dropped without a handshake. enable low mid-frame has no effect until the frame completes.
- cfg_update in any state: latches cfg_word and sets cfg_pending. In the same cycle as a CONFIG handshake, the update wins and cfg_pending stays set.
- The beat counter is LOG2_FRAME bits and is never reset except by aresetn or the tlast handshake.

Optional Feature:
- FFT_SRC_ERR_CNT_EN defined:
  - Adds output err_count (8 bits, saturating at 8'hFF) that increments once per cycle in which event_tlast_unexpected | event_tlast_missing is high. Both high in the same cycle counts once.
  - Adds input err_clear, which zeroes err_count and takes priority over an increment in the same cycle.
- Undefined: no err ports, event inputs unused.

Test Plan:
- LOG2_FRAME=3, reset release, enable=1, tready=1 on both channels, samples 1..8 streamed continuously → one config beat 16'h0001, then data beats 1..8 with tlast only on 8, frame_count=1.
- m_axis_config_tready held 0 for 5 cycles → config tvalid and tdata 16'h0001 stable all 5 cycles, no data beat before the config handshake.
- m_axis_data_tready toggled 1,0,0,1 during a frame → tdata/tlast stable while stalled, order preserved, tlast on beat 8 only.
- cfg_update with cfg_word=16'h0000 at beat 3 of a frame → frame completes, then config beat 16'h0000, then next frame.
- tready=0 with 17 samples offered, FIFO_DEPTH=16 → s_sample_tready low after 16, overflow=1; aresetn pulse mid-frame → all outputs 0, next frame resends config.
- FFT_SRC_ERR_CNT_EN: both event inputs pulsed together 3 times → err_count=3; err_clear asserted in the same cycle as an event → err_count=0.
